// File: rtl/inv_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module   : inv_sub_bytes_iter
// Purpose  : Iterative AES InvSubBytes engine. Applies the inverse S-box to
//            all 16 bytes of a 128-bit state, BYTES_PER_CYCLE bytes per cycle,
//            with valid/ready handshakes on input and output.
// Ports    : clk        - rising-edge clock
//            reset_n    - asynchronous active-low reset
//            in_valid   - data holds a state to accept
//            in_ready   - engine idle, can accept a state
//            data       - input state, byte i = data[8i+7:8i]
//            out_valid  - data_out holds a completed result
//            out_ready  - consumer accepts the result
//            data_out   - substituted state
//            busy       - engine is processing or holding a result
// Revision : 1.0 - initial release
// ============================================================================
module inv_sub_bytes_iter #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int c_n_steps = 16 / BYTES_PER_CYCLE;
    localparam int c_cnt_w   = (c_n_steps > 1) ? $clog2(c_n_steps) : 1;
    localparam int c_lg_b    = $clog2(BYTES_PER_CYCLE);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_n_steps - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_param_check
        $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] m;
        p = 8'h00;
        x = a;
        m = b;
        for (int i = 0; i < 8; i++) begin
            if (m[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            m = m >> 1;
        end
        return p;
    endfunction

    // Inverse S-box: inverse affine map, then multiplicative inverse computed
    // as a^254 (which also maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        logic [7:0] r;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);   // a^(2^i)
            r = gf_mul(r, p);   // accumulates a^(2+4+...+128) = a^254
        end
        return r;
    endfunction

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [127:0]       r_st;
    logic [127:0]       w_st_next;
    logic [3:0]         w_base;
    logic [7:0]         w_lane_out [BYTES_PER_CYCLE];

    // First byte of the group being substituted this cycle (cnt * B).
    assign w_base = 4'(r_cnt) << c_lg_b;

    // One S-box per lane; lane g always serves byte w_base + g.
    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
        logic [3:0] w_idx;
        assign w_idx         = w_base + 4'(g);
        assign w_lane_out[g] = inv_sbox(r_st[{w_idx, 3'b000} +: 8]);
    end

    // Byte b belongs to group b/B and is fed by lane b%B; only the active
    // group takes the substituted value, every other byte holds.
    for (genvar b = 0; b < 16; b++) begin : g_byte
        localparam logic [c_cnt_w-1:0] c_grp = c_cnt_w'(b / BYTES_PER_CYCLE);
        assign w_st_next[b*8 +: 8] = (r_cnt == c_grp) ? w_lane_out[b % BYTES_PER_CYCLE]
                                                      : r_st[b*8 +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (in_valid)              w_state_next = c_st_run;
            c_st_run:  if (r_cnt == c_cnt_last)   w_state_next = c_st_done;
            c_st_done: if (out_ready)             w_state_next = c_st_idle;
            default:                              w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_st  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_st  <= data;
                        r_cnt <= '0;
                    end
                end
                c_st_run: begin
                    r_st <= w_st_next;
                    if (r_cnt != c_cnt_last) r_cnt <= r_cnt + c_cnt_w'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign busy      = (r_state != c_st_idle);
    assign data_out  = r_st;

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_sub_bytes_iter
// Purpose  : Self-checking bench for inv_sub_bytes_iter. Five instances
//            (B = 4, 1, 2, 8, 16) share clock and reset. The reference
//            inverse S-box is obtained by inverting a forward S-box table
//            built from a brute-force field inverse and the forward affine map.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_sub_bytes_iter;

    localparam int NDUT = 5;
    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         iv   [NDUT];
    logic         ordy [NDUT];
    logic         ir   [NDUT];
    logic         ov   [NDUT];
    logic         bz   [NDUT];
    logic [127:0] din  [NDUT];
    logic [127:0] dout [NDUT];
    int           lat  [NDUT];

    int checks   = 0;
    int failures = 0;
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int GB = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16;
        initial lat[g] = 16 / GB;
        inv_sub_bytes_iter #(.BYTES_PER_CYCLE(GB)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .data      (din[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .data_out  (dout[g]),
            .busy      (bz[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] m = b;
        for (int i = 0; i < 8; i++) begin
            if (m[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            m = m >> 1;
        end
        return p;
    endfunction

    task automatic build_table();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] xv, y, s;
            xv = 8'(x);
            y  = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gm(xv, 8'(c)) == 8'h01) y = 8'(c);
            s = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
            inv_tab[s] = xv;
        end
    endtask

    function automatic logic [127:0] ref_state(input logic [127:0] d);
        logic [127:0] r = '0;
        logic [127:0] t;
        for (int i = 0; i < 16; i++) begin
            t = d >> (8 * i);
            r |= 128'(inv_tab[t[7:0]]) << (8 * i);
        end
        return r;
    endfunction

    // One full transaction on instance k; hold = cycles of out_ready=0 after out_valid.
    task automatic run_vec(input int k, input logic [127:0] d, input int hold,
                           input logic [127:0] exp, input string tag);
        int cyc = 0;
        while (!ir[k] && cyc < 50) begin step(); cyc++; end
        chk({tag, "_in_ready"}, 128'(ir[k]), 128'(1));
        din[k] = d; iv[k] = 1'b1; ordy[k] = (hold == 0);
        step();
        iv[k] = 1'b0; din[k] = rnd128();
        cyc = 0;
        while (!ov[k] && cyc < 50) begin step(); cyc++; end
        chk({tag, "_latency"}, 128'(cyc), 128'(lat[k]));
        chk({tag, "_data"}, dout[k], exp);
        if (hold > 0) begin
            repeat (hold) step();
            chk({tag, "_held"}, {dout[k][126:0], ov[k]}, {exp[126:0], 1'b1});
            ordy[k] = 1'b1;
        end
        step();
        chk({tag, "_back_idle"}, {126'(0), ov[k], ir[k]}, 128'(1));
        ordy[k] = 1'b0;
    endtask

    initial begin
        logic [127:0] d, e;
        int cyc, seen, k;

        build_table();
        for (int i = 0; i < NDUT; i++) begin
            iv[i] = 1'(($urandom % 2)); ordy[i] = 1'($urandom % 2); din[i] = rnd128();
        end

        // Reset values with random inputs, then after release.
        repeat (3) step();
        chk("rst_in_ready",  128'(ir[0]), 128'(1));
        chk("rst_out_valid", 128'(ov[0]), 128'(0));
        chk("rst_busy",      128'(bz[0]), 128'(0));
        chk("rst_data_out",  dout[0], 128'(0));
        for (int i = 0; i < NDUT; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; din[i] = '0; end
        reset_n = 1'b1;
        repeat (3) step();
        chk("idle_in_ready",  128'(ir[0]), 128'(1));
        chk("idle_out_valid", 128'(ov[0]), 128'(0));
        chk("idle_busy",      128'(bz[0]), 128'(0));
        chk("idle_data_out",  dout[0], 128'(0));

        // FIPS vector, B=4.
        run_vec(0, FIPS_IN, 0, FIPS_OUT, "fips_b4");

        // Every byte value once, across 16 states.
        for (int s = 0; s < 16; s++) begin
            d = '0;
            for (int i = 0; i < 16; i++) d |= 128'(8'(16 * s + ((i + s) % 16))) << (8 * i);
            run_vec(0, d, 0, ref_state(d), $sformatf("exh%0d", s));
        end

        // Spot values: 63->00 7c->01 00->52 01->09 ed->53 ff->7d.
        run_vec(0, 128'h0000_0000_0000_0000_0000_ffed_0100_7c63, 0,
                128'h5252_5252_5252_5252_5252_7d53_0952_0100, "spot");

        // Random states on random instances with random backpressure.
        for (int n = 0; n < 12; n++) begin
            k = $urandom_range(0, NDUT - 1);
            d = rnd128();
            run_vec(k, d, $urandom_range(0, 3), ref_state(d), $sformatf("rnd%0d_k%0d", n, k));
        end

        // Backpressure with input noise.
        d = rnd128(); e = ref_state(d);
        din[0] = d; iv[0] = 1'b1; ordy[0] = 1'b0;
        step();
        cyc = 0;
        while (!ov[0] && cyc < 50) begin
            iv[0] = 1'($urandom % 2); din[0] = rnd128(); step(); cyc++;
        end
        chk("bp_latency", 128'(cyc), 128'(4));
        for (int i = 0; i < 10; i++) begin
            iv[0] = 1'($urandom % 2); din[0] = rnd128();
            step();
            chk($sformatf("bp_hold%0d_data", i), dout[0], e);
            chk($sformatf("bp_hold%0d_ov_ir", i), {126'(0), ov[0], ir[0]}, 128'(2));
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        step();
        chk("bp_release", {126'(0), ov[0], ir[0]}, 128'(1));
        ordy[0] = 1'b0;
        step();
        chk("bp_no_second_accept", {126'(0), bz[0], ir[0]}, 128'(1));

        // Reset while cnt = 2.
        din[0] = rnd128(); iv[0] = 1'b1; ordy[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        step(); step();
        reset_n = 1'b0;
        #1;
        chk("midrst_outputs", {dout[0][124:0], ov[0], bz[0], ir[0]}, 128'(1));
        step(); step();
        reset_n = 1'b1;
        seen = 0;
        repeat (8) begin step(); if (ov[0]) seen = 1; end
        chk("midrst_no_result", 128'(seen), 128'(0));
        ordy[0] = 1'b0;
        run_vec(0, 128'(0), 0, {16{8'h52}}, "post_rst_zero");

        // Parameter sweep: B = 1, 2, 8, 16.
        for (int i = 1; i < NDUT; i++)
            run_vec(i, FIPS_IN, 0, FIPS_OUT, $sformatf("fips_k%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inv_sub_bytes_iter.md
# inv_sub_bytes_iter

Iterative AES InvSubBytes engine. It applies the inverse S-box (FIPS-197 §5.3.2) to all 16 bytes of a 128-bit state. The engine time-multiplexes `BYTES_PER_CYCLE` inverse S-box instances across several cycles. It sits in the decryption datapath after InvShiftRows, as the inverse counterpart of the forward byte-substitution stage. Valid/ready handshakes on both sides allow it to be stalled by the round controller.

## Interface
- `BYTES_PER_CYCLE`, default 4: bytes substituted per RUN cycle. Legal values are 1, 2, 4, 8 and 16. Any other value is a static elaboration error.
- One clock; reset is asynchronous and active-low.
- `clk`  input  1: rising-edge clock.
- `reset_n`  input  1: asynchronous active-low reset.
- `in_valid`  input  1: `data` is valid.
- `in_ready`  output  1: engine can accept a state.
- `data`  input  128: input state. Byte i is `data[8i+7:8i]`.
- `out_valid`  output  1: `data_out` holds a completed result.
- `out_ready`  input  1: consumer accepts the result.
- `data_out`  output  128: substituted state. Byte i = InvSbox(input byte i).
- `busy`  output  1: high in RUN or DONE.

## Operation
- Constant N = 16 / `BYTES_PER_CYCLE` (number of RUN cycles).
- **States:**
  - IDLE: `in_ready`=1.
  - RUN: `cnt` counts 0..N-1.
  - DONE: `out_valid`=1.
- **Transitions:**
  - IDLE→RUN on `in_valid && in_ready`. Capture `data` into the 128-bit working register `st` and clear `cnt`.
  - RUN: on cycle `cnt`=k, replace bytes k·B … k·B+B-1 of `st` with their inverse S-box values (B = `BYTES_PER_CYCLE`). Other bytes hold.
  - RUN→DONE when `cnt`=N-1 (that cycle's bytes are written). `cnt` is ⌈log2 N⌉ bits, minimum 1, and never wraps past N-1.
  - DONE→IDLE on `out_ready`.
- `data_out` is driven directly from `st`. It is stable while `out_valid`=1 and is don't-care otherwise. The bench only checks it under `out_valid`.
- `in_ready` = (state==IDLE). There is no overlap: a new state is not accepted in DONE even if `out_ready`=1 that cycle. The next acceptance is at the earliest one cycle after the DONE→IDLE transition.
- `in_valid` while not in IDLE is ignored. `data` changes outside an accept cycle have no effect.
- **Inverse S-box:** purely combinational.
  - Either a 256-entry case table or inverse affine transform followed by GF(2^8) multiplicative inverse (poly 0x11B, inverse of 0 = 0).
  - Both forms must match FIPS-197 Fig. 14 exactly.
- **Reset (any state, including mid-RUN):**
  - state=IDLE, `cnt`=0, `st`=0.
  - `in_ready`=1, `out_valid`=0, `busy`=0, `data_out`=0.
  - A partially processed state is discarded and no result is emitted.

## Timing
- Accept at edge E0. RUN occupies edges E1..EN. `out_valid` is high in the cycle after EN.
- Accept-to-`out_valid` latency is N cycles: 4 for the default, 1 for B=16, 16 for B=1.
- With `out_ready` held high, `out_valid` is high for exactly one cycle and `in_ready` rises the following cycle. Peak throughput is one state per N+2 cycles.
- Backpressure: `out_valid` and `data_out` hold indefinitely until `out_ready`.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Critical path is one inverse S-box plus the byte-select mux.

## Test plan
- **Reset values:** assert `reset_n`=0 with random inputs → `in_ready`=1, `out_valid`=0, `busy`=0, `data_out`=0. Release, idle 3 cycles → unchanged.
- **FIPS vector:** B=4, `data`=0xd42711aee0bf98f1b8b45de51e415230, `out_ready`=1 → `out_valid` exactly 4 cycles after accept with `data_out`=0x193de3bea0f4e22b9ac68d2ae9f84808. `in_ready`=1 two cycles after the accept-to-DONE sequence completes.
- **Exhaustive S-box:** feed 16 states covering byte values 0x00–0xFF, each value once per lane across states → every byte matches InvSbox. Spot checks: 0x63→0x00, 0x7C→0x01, 0x00→0x52, 0x01→0x09, 0xED→0x53, 0xFF→0x7D.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` while toggling `in_valid`/`data` → `data_out` stable, `in_ready`=0, no second accept. Raise `out_ready` → one transfer, then IDLE.
- **Reset mid-RUN:** accept a state, assert `reset_n`=0 at `cnt`=2 → `out_valid` never asserts for that state. After release, a new accept of 0x00…00 yields 0x5252…52.
- **Parameter sweep:** repeat the FIPS vector for B=1, 2, 8, 16 → identical result with latency 16, 8, 2, 1 cycles respectively.
